image_pixel_streamer: RTL and testbench

Reads one stored 784-pixel image back out of the input BRAM and presents it as a backpressured pixel stream to the first network layer. It sits directly downstream of `bram_storage`. It starts when the image is complete, requests read access, and sweeps the BRAM address. It absorbs the BRAM's one-cycle read latency and emits pixels in address order, with index and last-pixel markers.

---
 rtl/nn_input_pkg.sv | 18 +
 rtl/pixel_skid_fifo.sv | 71 +++++++
 rtl/image_pixel_streamer.sv | 122 ++++++++++++
 tb/tb_image_pixel_streamer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_input_pkg.sv
// Shared constants, pixel type and streamer FSM encoding for the network
// input path (storage BRAM -> pixel stream).
package nn_input_pkg;

    localparam int IMG_PIXELS  = 784;
    localparam int PIXEL_W     = 8;
    localparam int BRAM_ADDR_W = 16;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        STREAM,
        DONE
    } streamer_state_t;

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry {index, data} FIFO. Entry 0 is always the head, so the head
// outputs come straight from registers and never from a read mux.
module pixel_skid_fifo #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic [IDX_W-1:0]  push_idx,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [IDX_W-1:0]  head_idx,
    output logic [1:0]        occupancy,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] tail_data;
    logic [IDX_W-1:0]  tail_idx;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (occupancy == 2'd2);
    assign empty   = (occupancy == 2'd0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy <= 2'd0;
            head_data <= '0;
            head_idx  <= '0;
            tail_data <= '0;
            tail_idx  <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (empty) begin
                        head_data <= push_data;
                        head_idx  <= push_idx;
                    end else begin
                        tail_data <= push_data;
                        tail_idx  <= push_idx;
                    end
                    occupancy <= occupancy + 2'd1;
                end
                2'b01: begin
                    head_data <= tail_data;
                    head_idx  <= tail_idx;
                    occupancy <= occupancy - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind whatever remains.
                    if (occupancy == 2'd1) begin
                        head_data <= push_data;
                        head_idx  <= push_idx;
                    end else begin
                        head_data <= tail_data;
                        head_idx  <= tail_idx;
                        tail_data <= push_data;
                        tail_idx  <= push_idx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/image_pixel_streamer.sv
// Sweeps the stored image out of the input BRAM and presents it as a
// backpressured pixel stream, hiding the BRAM's one-cycle read latency.
module image_pixel_streamer
    import nn_input_pkg::*;
#(
    parameter int NUM_PIXELS = IMG_PIXELS,
    parameter int ADDR_W     = BRAM_ADDR_W,
    parameter int DATA_W     = PIXEL_W,
    parameter int IDX_W      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              image_written,
    output logic              read_request,
    input  logic              read_enable,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_data,
    output logic [DATA_W-1:0] pix_data,
    output logic [IDX_W-1:0]  pix_index,
    output logic              pix_last,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              busy,
    output logic              done
);

    localparam int                CNT_W    = $clog2(NUM_PIXELS + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(NUM_PIXELS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_PIXELS - 1);

    streamer_state_t  state;
    logic             iw_q;
    logic [CNT_W-1:0] cnt;
    logic             vld_p1;
    logic [IDX_W-1:0] idx_p1;

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [1:0]       fifo_occ;
    logic [2:0]       occ_sum;
    logic             slot_ok;
    logic             issue;

    assign bram_addr = ADDR_W'(cnt);
    assign pix_valid = !fifo_empty;
    assign pix_last  = pix_valid && (pix_index == LAST_IDX);
    assign fifo_pop  = pix_valid && pix_ready;

    // Room for one more word counting what is stored, what is in flight and
    // what leaves this cycle.
    assign occ_sum = {1'b0, fifo_occ} + {2'b00, vld_p1} - {2'b00, fifo_pop};
    assign slot_ok = fifo_full ? (fifo_pop && !vld_p1) : (occ_sum <= 3'd1);
    assign issue   = (state == STREAM) && read_enable && (cnt < CNT_MAX) && slot_ok;

    // Stage p0: address issue and control FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            iw_q         <= 1'b1;
            read_request <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cnt          <= '0;
            vld_p1       <= 1'b0;
            idx_p1       <= '0;
        end else begin
            iw_q   <= image_written;
            done   <= 1'b0;
            vld_p1 <= issue;
            if (issue) begin
                cnt    <= cnt + 1'b1;
                idx_p1 <= IDX_W'(cnt);
            end
            case (state)
                IDLE: begin
                    if (image_written && !iw_q) begin
                        state        <= REQ;
                        read_request <= 1'b1;
                        busy         <= 1'b1;
                        cnt          <= '0;
                    end
                end
                REQ: begin
                    if (read_enable) state <= STREAM;
                end
                STREAM: begin
                    if (fifo_pop && (pix_index == LAST_IDX)) begin
                        state        <= DONE;
                        read_request <= 1'b0;
                        done         <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage p1: BRAM word returns and is captured with its index
    pixel_skid_fifo #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (vld_p1),
        .push_data (bram_data),
        .push_idx  (idx_p1),
        .pop       (fifo_pop),
        .head_data (pix_data),
        .head_idx  (pix_index),
        .occupancy (fifo_occ),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_image_pixel_streamer.sv
// Directed bench for image_pixel_streamer: table of full-image passes plus
// hand-written edge-semantics and mid-stream reset sequences.
module tb_image_pixel_streamer;
    import nn_input_pkg::*;

    localparam int N = 784;

    logic        clk = 1'b0;
    logic        rst;
    logic        image_written;
    logic        read_request;
    logic        read_enable;
    logic [15:0] bram_addr;
    logic [7:0]  bram_data;
    logic [7:0]  pix_data;
    logic [9:0]  pix_index;
    logic        pix_last;
    logic        pix_valid;
    logic        pix_ready;
    logic        busy;
    logic        done;

    image_pixel_streamer dut (
        .clk           (clk),
        .rst           (rst),
        .image_written (image_written),
        .read_request  (read_request),
        .read_enable   (read_enable),
        .bram_addr     (bram_addr),
        .bram_data     (bram_data),
        .pix_data      (pix_data),
        .pix_index     (pix_index),
        .pix_last      (pix_last),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    pixel_t mem [0:N-1];
    initial for (int i = 0; i < N; i++) mem[i] = pixel_t'(i);

    always_ff @(posedge clk)
        bram_data <= (int'(bram_addr) < N) ? mem[int'(bram_addr)] : 8'h00;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input bit ok, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Environment state shared between driver, monitor and main sequence
    int ready_pct = 100;
    bit gap_en = 0;
    bit gap_done = 0;
    bit gap_low = 0;
    int gap_cnt = 0;
    bit mon_en = 0;

    int cyc, first_req, first_vld, first_xfer, last_xfer, done_cyc;
    int xfer_cnt, done_cnt, exp_idx;
    bit stall_prev;
    logic [7:0] stall_data;
    logic [9:0] stall_idx;

    task automatic reset_stats();
        cyc = 0; first_req = -1; first_vld = -1; first_xfer = -1;
        last_xfer = -1; done_cyc = -1; xfer_cnt = 0; done_cnt = 0;
        exp_idx = 0; stall_prev = 0;
    endtask

    // Grant and ready driver: grant follows read_request by one cycle
    initial begin
        bit prev_req;
        prev_req = 0;
        read_enable = 0;
        pix_ready = 1;
        forever begin
            @(posedge clk);
            #1;
            if (gap_en && !gap_done && read_enable && bram_addr == 16'd100) begin
                gap_cnt = 5;
                gap_done = 1;
            end
            if (gap_cnt > 0) begin
                read_enable = 0;
                gap_low = 1;
                gap_cnt--;
            end else begin
                gap_low = 0;
                read_enable = prev_req && read_request;
            end
            prev_req = read_request;
            pix_ready = (ready_pct >= 100) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Stream monitor
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cyc++;
                if (read_request && first_req < 0) first_req = cyc;
                if (pix_valid && first_vld < 0) first_vld = cyc;
                if (busy)
                    chk("fifo_occupancy_le2", dut.u_fifo.occupancy <= 2'd2,
                        int'(dut.u_fifo.occupancy), 2);
                if (stall_prev && pix_valid) begin
                    chk("stall_data_stable", pix_data == stall_data, int'(pix_data), int'(stall_data));
                    chk("stall_index_stable", pix_index == stall_idx, int'(pix_index), int'(stall_idx));
                end
                stall_prev = pix_valid && !pix_ready;
                stall_data = pix_data;
                stall_idx  = pix_index;
                if (pix_valid && pix_ready) begin
                    chk("pix_index", int'(pix_index) == exp_idx, int'(pix_index), exp_idx);
                    chk("pix_data", int'(pix_data) == (exp_idx % 256), int'(pix_data), exp_idx % 256);
                    chk("pix_last", pix_last == (exp_idx == N - 1), int'(pix_last), int'(exp_idx == N - 1));
                    exp_idx++;
                    xfer_cnt++;
                    if (first_xfer < 0) first_xfer = cyc;
                    last_xfer = cyc;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (gap_low)
                    chk("addr_held_in_gap", bram_addr == 16'd100, int'(bram_addr), 100);
            end
        end
    end

    task automatic wait_xfers(input int target);
        int n = 0;
        while (xfer_cnt < target && n < 8000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (xfer_cnt < target) chk("xfer_wait_timeout", 1'b0, xfer_cnt, target);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < 8000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (done_cnt == 0) chk("done_wait_timeout", 1'b0, 0, 1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, busy == 1'b0, int'(busy), 0);
        chk({tag, "_read_request"}, read_request == 1'b0, int'(read_request), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_read_request"}, read_request == 1'b0, int'(read_request), 0);
        chk({tag, "_bram_addr"}, bram_addr == 16'd0, int'(bram_addr), 0);
        chk({tag, "_pix_data"}, pix_data == 8'd0, int'(pix_data), 0);
        chk({tag, "_pix_index"}, pix_index == 10'd0, int'(pix_index), 0);
        chk({tag, "_pix_last"}, pix_last == 1'b0, int'(pix_last), 0);
        chk({tag, "_pix_valid"}, pix_valid == 1'b0, int'(pix_valid), 0);
        chk({tag, "_busy"}, busy == 1'b0, int'(busy), 0);
        chk({tag, "_done"}, done == 1'b0, int'(done), 0);
    endtask

    typedef struct {
        int ready_pct;
        bit gap_en;
        bit full_rate;
        int exp_xfers;
        int exp_done;
        int exp_latency;
    } pass_vec_t;

    pass_vec_t vecs [3];

    initial begin
        // basic sweep, random backpressure, grant gap after 100 addresses
        vecs[0] = '{ready_pct: 100, gap_en: 0, full_rate: 1, exp_xfers: N, exp_done: 1, exp_latency: 4};
        vecs[1] = '{ready_pct: 50,  gap_en: 0, full_rate: 0, exp_xfers: N, exp_done: 1, exp_latency: 4};
        vecs[2] = '{ready_pct: 100, gap_en: 1, full_rate: 0, exp_xfers: N, exp_done: 1, exp_latency: 4};

        rst = 1;
        image_written = 0;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst = 0;
        reset_stats();
        mon_en = 1;

        for (int v = 0; v < 3; v++) begin
            ready_pct = vecs[v].ready_pct;
            gap_en    = vecs[v].gap_en;
            gap_done  = 0;
            reset_stats();
            @(posedge clk);
            #1 image_written = 1;
            wait_done();
            repeat (3) @(posedge clk);
            #1;
            chk($sformatf("pass%0d_xfers", v), xfer_cnt == vecs[v].exp_xfers, xfer_cnt, vecs[v].exp_xfers);
            chk($sformatf("pass%0d_done_count", v), done_cnt == vecs[v].exp_done, done_cnt, vecs[v].exp_done);
            chk($sformatf("pass%0d_done_after_last", v), done_cyc == last_xfer + 1, done_cyc, last_xfer + 1);
            chk($sformatf("pass%0d_first_valid_latency", v), first_vld - first_req == vecs[v].exp_latency,
                first_vld - first_req, vecs[v].exp_latency);
            check_idle($sformatf("pass%0d_end", v));
            if (vecs[v].full_rate)
                chk($sformatf("pass%0d_consecutive", v), last_xfer - first_xfer == vecs[v].exp_xfers - 1,
                    last_xfer - first_xfer, vecs[v].exp_xfers - 1);
            if (vecs[v].gap_en)
                chk($sformatf("pass%0d_gap_seen", v), gap_done == 1'b1, int'(gap_done), 1);
            gap_en = 0;
            image_written = 0;
            repeat (2) @(posedge clk);
        end
        ready_pct = 100;

        // Level high out of reset must not start; mid-stream edge is ignored
        @(posedge clk);
        #1 rst = 1;
        image_written = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        repeat (20) @(posedge clk);
        #1;
        check_idle("level_out_of_reset");
        reset_stats();
        image_written = 0;
        @(posedge clk);
        #1 image_written = 1;
        wait_xfers(400);
        image_written = 0;
        @(posedge clk);
        #1 image_written = 1;
        wait_done();
        repeat (30) @(posedge clk);
        #1;
        chk("edge_xfers", xfer_cnt == N, xfer_cnt, N);
        chk("edge_done_count", done_cnt == 1, done_cnt, 1);
        check_idle("edge_end");
        image_written = 0;
        repeat (2) @(posedge clk);

        // Reset at pixel 300, then a fresh edge restarts from index 0
        reset_stats();
        @(posedge clk);
        #1 image_written = 1;
        wait_xfers(300);
        @(posedge clk);
        #1 rst = 1;
        #1;
        check_reset_outputs("mid_reset");
        repeat (2) @(posedge clk);
        #1 rst = 0;
        repeat (10) @(posedge clk);
        #1;
        check_idle("after_mid_reset");
        reset_stats();
        image_written = 0;
        @(posedge clk);
        #1 image_written = 1;
        wait_done();
        repeat (3) @(posedge clk);
        #1;
        chk("restart_xfers", xfer_cnt == N, xfer_cnt, N);
        chk("restart_done_count", done_cnt == 1, done_cnt, 1);
        check_idle("restart_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
